// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: single-outstanding request FSM feeding a small
// {PC, instruction} FIFO that presents entries to the decoder.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallIF,
  input  logic        jumpEn,
  input  logic [31:0] jumpAddr,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memRdy,
  input  logic [31:0] memInst,
  output logic        DecEn,
  output logic [31:0] instPC,
  output logic [31:0] inst
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  logic [1:0]    state;
  logic [31:0]   pc;
  logic [31:0]   jump_pc;
  logic [AW:0]   count;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          has_space;
  logic          push;
  logic          pop;

  logic [31:0] fifo_pc   [DEPTH];
  logic [31:0] fifo_inst [DEPTH];

  always_comb begin
    jump_pc   = jumpAddr & 32'hFFFF_FFFC;
    has_space = (count < FULL);
    push      = (state == WAIT) && memRdy && !jumpEn;
    pop       = !jumpEn && !stallIF && (count != '0);
  end

  // Request FSM; space is checked at issue, so a granted response always fits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      memReq  <= 1'b0;
      memAddr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (jumpEn) begin
            pc     <= jump_pc;
            memReq <= 1'b0;
          end else if (has_space) begin
            memReq  <= 1'b1;
            memAddr <= pc;
            state   <= WAIT;
          end else begin
            memReq <= 1'b0;
          end
        end
        WAIT: begin
          if (jumpEn) begin
            pc <= jump_pc;
            if (memRdy) begin
              memReq <= 1'b0;
              state  <= IDLE;
            end else begin
              state <= DISCARD;
            end
          end else if (memRdy) begin
            pc     <= pc + 32'd4;
            memReq <= 1'b0;
            state  <= IDLE;
          end
        end
        DISCARD: begin
          // Stale request stays on the bus until memory answers, then is dropped.
          if (jumpEn) pc <= jump_pc;
          if (memRdy) begin
            memReq <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          memReq <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[tail]   <= memAddr;
      fifo_inst[tail] <= memInst;
    end
  end

  // Output stage: a redirect flush takes priority over push and pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      head   <= '0;
      tail   <= '0;
      DecEn  <= 1'b0;
      instPC <= '0;
      inst   <= '0;
    end else if (jumpEn) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
      DecEn <= 1'b0;
    end else begin
      DecEn <= pop;
      if (pop) begin
        instPC <= fifo_pc[head];
        inst   <= fifo_inst[head];
        head   <= head + 1'b1;
      end
      if (push) tail <= tail + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized scoreboard bench for inst_fetch_queue with a queue-based reference model.
module tb_inst_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallIF = 1'b0;
  logic        jumpEn = 1'b0;
  logic [31:0] jumpAddr = '0;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memRdy = 1'b0;
  logic [31:0] memInst = '0;
  logic        DecEn;
  logic [31:0] instPC;
  logic [31:0] inst;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stallIF(stallIF), .jumpEn(jumpEn), .jumpAddr(jumpAddr),
    .memReq(memReq), .memAddr(memAddr), .memRdy(memRdy), .memInst(memInst),
    .DecEn(DecEn), .instPC(instPC), .inst(inst)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0010_0093;
  endfunction

  // Reference model: PC, instruction buffer, expected decoder stream.
  logic [31:0] m_pc = RESET_PC;
  logic [63:0] m_fifo[$];
  logic [63:0] exq[$];
  bit          stale = 0;
  int unsigned m_pushes = 0;

  // Memory-side driver state.
  bit          pend = 0;
  logic [31:0] req_addr = '0;
  int unsigned wait_left = 0;
  logic [31:0] last_req = '0;
  bit          seen_wrap = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc = RESET_PC;
      m_fifo.delete();
      exq.delete();
      stale = 0;
    end else begin
      bit acc;
      acc = pend && memRdy && !jumpEn && !stale;
      if (pend && memRdy) stale = 0;
      else if (pend && jumpEn) stale = 1;
      if (jumpEn) begin
        m_fifo.delete();
        m_pc = jumpAddr & 32'hFFFF_FFFC;
      end else begin
        int unsigned pre;
        pre = m_fifo.size();
        if (!stallIF && m_fifo.size() > 0) exq.push_back(m_fifo.pop_front());
        if (acc) begin
          chk("no_overflow", 64'(pre < DEPTH), 64'd1);
          m_fifo.push_back({m_pc, memInst});
          m_pc = m_pc + 32'd4;
          m_pushes++;
        end
      end
    end
  end

  // Monitor: every decoder-facing cycle is matched against the expected stream.
  always @(negedge clk) begin
    if (rst) begin
      if (exq.size() > 0) begin
        logic [63:0] e;
        e = exq.pop_front();
        chk("dec_en", 64'(DecEn), 64'd1);
        chk("dec_data", {instPC, inst}, e);
      end else begin
        chk("dec_idle", 64'(DecEn), 64'd0);
      end
    end
  end

  task automatic cycle(input bit st, input bit jmp, input logic [31:0] ja,
                       input int unsigned maxlat, input bit spur);
    @(negedge clk);
    if (rst) begin
      if (memRdy && pend) begin
        pend = 0;
        chk("req_drop", 64'(memReq), 64'd0);
      end
      memRdy = 1'b0;
      if (pend) begin
        chk("req_hold", {31'd0, memReq, memAddr}, {31'd0, 1'b1, req_addr});
      end else if (memReq) begin
        chk("req_addr", 64'(memAddr), 64'(m_pc));
        if (memAddr == 32'h0 && last_req == 32'hFFFF_FFFC) seen_wrap = 1;
        last_req  = memAddr;
        pend      = 1;
        req_addr  = memAddr;
        wait_left = $urandom_range(maxlat - 1, 0);
      end
      if (pend) begin
        if (wait_left == 0) begin
          memRdy  = 1'b1;
          memInst = mk_inst(req_addr);
        end else begin
          wait_left--;
        end
      end else if (spur && ($urandom % 8 == 0)) begin
        memRdy  = 1'b1;
        memInst = $urandom;
      end
    end
    stallIF  = st;
    jumpEn   = jmp;
    jumpAddr = ja;
  endtask

  initial begin
    int unsigned snap;
    bit found;

    repeat (3) cycle(0, 0, '0, 1, 0);
    chk("rst_memReq", 64'(memReq), 64'd0);
    chk("rst_memAddr", 64'(memAddr), 64'd0);
    chk("rst_DecEn", 64'(DecEn), 64'd0);
    chk("rst_instPC", 64'(instPC), 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    repeat (30) cycle(0, 0, '0, 1, 0);

    // Full-buffer hold under sustained stall.
    cycle(1, 1, 32'h0, 1, 0);
    snap = m_pushes;
    repeat (16) cycle(1, 0, '0, 1, 0);
    chk("stall_fills", 64'(m_pushes - snap), 64'(DEPTH));
    chk("stall_noreq", 64'(memReq), 64'd0);
    chk("stall_nodec", 64'(DecEn), 64'd0);
    repeat (20) cycle(0, 0, '0, 1, 0);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ja;
      ja = ($urandom % 2 == 0) ? ($urandom % 32'h400) : $urandom;
      cycle(($urandom % 4) == 0, ($urandom % 40) == 0, ja, 4, 1);
    end
    repeat (20) cycle(0, 0, '0, 2, 0);

    seen_wrap = 0;
    cycle(0, 1, 32'hFFFF_FFFF, 1, 0);
    repeat (20) cycle(0, 0, '0, 1, 0);
    chk("pc_wrap", 64'(seen_wrap), 64'd1);

    // Asynchronous reset mid-request with entries buffered.
    cycle(1, 1, 32'h40, 3, 0);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_fifo.size() >= 2 && pend) begin
        found = 1;
        break;
      end
      cycle(1, 0, '0, 3, 0);
    end
    chk("midwait_reached", 64'(found), 64'd1);
    #2;
    rst = 1'b0;
    pend = 0;
    memRdy = 1'b0;
    stallIF = 1'b0;
    #1;
    chk("arst_memReq", 64'(memReq), 64'd0);
    chk("arst_memAddr", 64'(memAddr), 64'd0);
    chk("arst_DecEn", 64'(DecEn), 64'd0);
    chk("arst_instPC", 64'(instPC), 64'd0);
    chk("arst_inst", 64'(inst), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (30) cycle(0, 0, '0, 2, 0);

    repeat (20) cycle(1, 0, '0, 1, 0);
    repeat (20) cycle(0, 1, 32'h200, 1, 0);
    repeat (3) cycle(0, 0, '0, 1, 0);
    chk("drain", 64'(exq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
